// File: rtl/cdc_evt_sched_pkg.sv
// Shared types and round-robin helper for the cdc_evt_sched toggle-handshake event scheduler.
// Optional drop counters are enabled in the top with macro CDC_EVT_DROP_CNT_EN.
package cdc_evt_sched_pkg;

  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_IDX_W = 4;

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of pend at or after ptr, wrapping at n; ptr must be < n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   pend,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input int unsigned          n);
    pick_t       r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !r.valid && pend[idx[MAX_IDX_W-1:0]]) begin
        r.valid = 1'b1;
        r.idx   = idx[MAX_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_evt_sched_tgl2pls.sv
// Toggle-to-pulse converter: pulse_o is high for the cycle in which d_i differs from its
// registered copy.
module cdc_evt_sched_tgl2pls (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic pulse_o
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_i;
  end

  assign pulse_o = d_i ^ d_q;

endmodule

// File: rtl/cdc_evt_sched.sv
// Source-domain scheduler for a toggle-handshake CDC event channel: coalesces requester pulses,
// round-robin arbitrates and keeps one event in flight. Macro CDC_EVT_DROP_CNT_EN adds drop counters.
module cdc_evt_sched
  import cdc_evt_sched_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned CNT_W = 8,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             ack_tgl_i,
  output logic             tgl_o,
  output logic [ID_W-1:0]  id_o,
  output logic             busy_o,
  output logic [N_REQ-1:0] pend_o,
  output logic [N_REQ-1:0] done_o
`ifdef CDC_EVT_DROP_CNT_EN
  ,
  input  logic                   drop_clr_i,
  output logic [N_REQ*CNT_W-1:0] drop_cnt_o
`endif
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             tgl_q, tgl_d;
  logic             ack_pls;
  logic [N_REQ-1:0] grant_mask;
  logic [ID_W-1:0]  grant_idx;
  pick_t            pick;

  cdc_evt_sched_tgl2pls u_ack_tgl2pls (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (ack_tgl_i),
    .pulse_o(ack_pls)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    tgl_d      = tgl_q;
    grant_mask = '0;
    done_o     = '0;
    pick       = rr_pick(MAX_REQ'(pend_q), MAX_IDX_W'(rr_q), N_REQ);
    grant_idx  = pick.idx[ID_W-1:0];
    case (state_q)
      IDLE: begin
        if (pick.valid) begin
          grant_mask[grant_idx] = 1'b1;
          id_d    = grant_idx;
          tgl_d   = ~tgl_q;
          rr_d    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_pls) begin
          done_o[id_q] = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A request landing on its own grant edge re-arms the flag as a fresh event.
    pend_d = (pend_q & ~grant_mask) | req_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      rr_q    <= '0;
      id_q    <= '0;
      tgl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      tgl_q   <= tgl_d;
    end
  end

  assign tgl_o  = tgl_q;
  assign id_o   = id_q;
  assign busy_o = (state_q == WAIT_ACK);
  assign pend_o = pend_q;

`ifdef CDC_EVT_DROP_CNT_EN
  logic [N_REQ-1:0][CNT_W-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (drop_clr_i) begin
        drop_d[i] = '0;
      end else if (req_i[i] && pend_q[i] && !grant_mask[i] && (drop_q[i] != '1)) begin
        drop_d[i] = drop_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_cnt_o = drop_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
